// File: rtl/multi_counter.sv
// Bank of independent up/down counters with variable step, parallel load,
// per-cycle saturate/wrap selection and sticky overflow/underflow flags.
module multi_counter #(
  parameter int WIDTH    = 8,
  parameter int INC_SIZE = 1,
  parameter int DEC_SIZE = 1,
  parameter int CHANNELS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS*INC_SIZE-1:0] inc,
  input  logic [CHANNELS*DEC_SIZE-1:0] dec,
  input  logic [CHANNELS-1:0]          load,
  input  logic [CHANNELS*WIDTH-1:0]    load_val,
  input  logic [CHANNELS-1:0]          mode,
  input  logic [CHANNELS-1:0]          clr_flags,
  output logic [CHANNELS*WIDTH-1:0]    count,
  output logic [CHANNELS-1:0]          ovf,
  output logic [CHANNELS-1:0]          unf,
  output logic [CHANNELS-1:0]          at_max,
  output logic [CHANNELS-1:0]          at_zero
);

  // Two guard bits: the top one is the sign, the next one marks a carry past 2^WIDTH-1.
  localparam int NW = WIDTH + 2;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [WIDTH-1:0] count_reg, count_next;
      logic             ovf_reg, ovf_next;
      logic             unf_reg, unf_next;
      logic [NW-1:0]    net;
      logic             net_over, net_under;
      logic [WIDTH-1:0] load_val_ch;

      assign load_val_ch = load_val[gi*WIDTH +: WIDTH];

      // Two's complement difference; steps are at most 2^WIDTH-1 so it never leaves NW bits.
      assign net = {2'b00, count_reg}
                 + NW'(inc[gi*INC_SIZE +: INC_SIZE])
                 - NW'(dec[gi*DEC_SIZE +: DEC_SIZE]);

      assign net_under = net[NW-1];
      assign net_over  = ~net[NW-1] & net[NW-2];

      always_comb begin
        count_next = net[WIDTH-1:0];
        ovf_next   = ovf_reg & ~clr_flags[gi];
        unf_next   = unf_reg & ~clr_flags[gi];
        if (load[gi]) begin
          count_next = load_val_ch;
        end else if (net_over) begin
          ovf_next = 1'b1;
          if (!mode[gi]) begin
            count_next = '1;
          end
        end else if (net_under) begin
          unf_next = 1'b1;
          if (!mode[gi]) begin
            count_next = '0;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count_reg <= '0;
          ovf_reg   <= 1'b0;
          unf_reg   <= 1'b0;
        end else begin
          count_reg <= count_next;
          ovf_reg   <= ovf_next;
          unf_reg   <= unf_next;
        end
      end

      assign count[gi*WIDTH +: WIDTH] = count_reg;
      assign ovf[gi]     = ovf_reg;
      assign unf[gi]     = unf_reg;
      assign at_max[gi]  = &count_reg;
      assign at_zero[gi] = ~|count_reg;
    end
  endgenerate

endmodule

// File: tb/tb_multi_counter.sv
// Scoreboarded random/directed bench for multi_counter (WIDTH=8, 2-bit steps, 2 channels).
module tb_multi_counter;
  localparam int W  = 8;
  localparam int IS = 2;
  localparam int DS = 2;
  localparam int CH = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CH*IS-1:0]  inc = '0;
  logic [CH*DS-1:0]  dec = '0;
  logic [CH-1:0]     load = '0;
  logic [CH*W-1:0]   load_val = '0;
  logic [CH-1:0]     mode = '0;
  logic [CH-1:0]     clr_flags = '0;
  logic [CH*W-1:0]   count;
  logic [CH-1:0]     ovf, unf, at_max, at_zero;

  multi_counter #(.WIDTH(W), .INC_SIZE(IS), .DEC_SIZE(DS), .CHANNELS(CH)) dut (
    .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .load(load), .load_val(load_val),
    .mode(mode), .clr_flags(clr_flags), .count(count), .ovf(ovf), .unf(unf),
    .at_max(at_max), .at_zero(at_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH*W-1:0] cnt;
    logic [CH-1:0]   ovf;
    logic [CH-1:0]   unf;
    logic [CH-1:0]   amax;
    logic [CH-1:0]   azero;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   txn      = 0;

  // Reference state: plain integers, updated by the rules of the counter.
  int mc[CH];
  bit mo[CH];
  bit mu[CH];

  function automatic exp_t model_snapshot();
    exp_t e;
    for (int c = 0; c < CH; c++) begin
      e.cnt[c*W +: W] = W'(mc[c]);
      e.ovf[c]   = mo[c];
      e.unf[c]   = mu[c];
      e.amax[c]  = (mc[c] == (1 << W) - 1);
      e.azero[c] = (mc[c] == 0);
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      mc[c] = 0; mo[c] = 0; mu[c] = 0;
    end
  endtask

  task automatic model_step();
    int net;
    for (int c = 0; c < CH; c++) begin
      if (clr_flags[c]) begin
        mo[c] = 0; mu[c] = 0;
      end
      if (load[c]) begin
        mc[c] = int'(load_val[c*W +: W]);
      end else begin
        net = mc[c] + int'(inc[c*IS +: IS]) - int'(dec[c*DS +: DS]);
        if (net > 255) begin
          mo[c] = 1;
          mc[c] = mode[c] ? net - 256 : 255;
        end else if (net < 0) begin
          mu[c] = 1;
          mc[c] = mode[c] ? net + 256 : 0;
        end else begin
          mc[c] = net;
        end
      end
    end
  endtask

  // One cycle of stimulus; the expected post-edge state is queued for the monitor.
  task automatic drive(input bit rstn, input logic [CH*IS-1:0] inc_v, input logic [CH*DS-1:0] dec_v,
                       input logic [CH-1:0] load_v, input logic [CH*W-1:0] lv,
                       input logic [CH-1:0] mode_v, input logic [CH-1:0] clr_v);
    @(negedge clk);
    rst_n = rstn; inc = inc_v; dec = dec_v; load = load_v;
    load_val = lv; mode = mode_v; clr_flags = clr_v;
    if (!rstn) model_reset();
    else model_step();
    exp_q.push_back(model_snapshot());
  endtask

  task automatic async_reset_pulse();
    exp_t e;
    @(negedge clk);
    inc = 4'b1111; dec = '0; load = '0; clr_flags = '0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    e = model_snapshot();
    n_checks++;
    if ({count, ovf, unf, at_max, at_zero} !== e) begin
      n_fail++;
      $display("FAIL async_reset: got cnt=%h ovf=%b unf=%b amax=%b azero=%b want cnt=%h ovf=%b unf=%b amax=%b azero=%b",
               count, ovf, unf, at_max, at_zero, e.cnt, e.ovf, e.unf, e.amax, e.azero);
    end else begin
      $display("async_reset ok cnt=%h", count);
    end
    exp_q.push_back(e);
  endtask

  // Monitor: the DUT presents a new state after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        n_checks++;
        if ({count, ovf, unf, at_max, at_zero} !== e) begin
          n_fail++;
          $display("FAIL txn %0d state: got cnt=%h ovf=%b unf=%b amax=%b azero=%b want cnt=%h ovf=%b unf=%b amax=%b azero=%b",
                   txn, count, ovf, unf, at_max, at_zero, e.cnt, e.ovf, e.unf, e.amax, e.azero);
        end else begin
          $display("txn %0d cnt=%h ovf=%b unf=%b amax=%b azero=%b", txn, count, ovf, unf, at_max, at_zero);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete, pending=%0d required 0", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    // Reset held with increments pending on both channels.
    for (int i = 0; i < 3; i++) drive(0, 4'b1111, '0, '0, '0, '0, '0);

    // Saturate ceiling on ch0; ch1 idle.
    drive(1, '0, '0, 2'b01, {8'd0, 8'd250}, 2'b00, '0);
    for (int i = 0; i < 3; i++) drive(1, 4'b0011, '0, '0, '0, 2'b00, '0);

    // Wrap both directions on ch1.
    drive(1, '0, '0, 2'b10, {8'd254, 8'd0}, 2'b10, '0);
    drive(1, 4'b1100, '0, '0, '0, 2'b10, '0);
    drive(1, '0, '0, 2'b10, {8'd1, 8'd0}, 2'b10, 2'b10);
    drive(1, '0, 4'b1100, '0, '0, 2'b10, '0);

    // Simultaneous events on ch0.
    drive(1, '0, '0, 2'b01, {8'd0, 8'd10}, 2'b00, 2'b01);
    drive(1, 4'b0010, 4'b0010, '0, '0, 2'b00, '0);
    drive(1, 4'b0001, 4'b0011, '0, '0, 2'b00, '0);
    drive(1, 4'b0011, '0, 2'b01, {8'd0, 8'd77}, 2'b00, '0);

    // Flag priority: set beats clear, then a bare clear.
    drive(1, '0, '0, 2'b01, {8'd0, 8'd0}, 2'b00, '0);
    drive(1, '0, 4'b0001, '0, '0, 2'b00, '0);
    drive(1, '0, 4'b0001, '0, '0, 2'b00, 2'b01);
    drive(1, '0, '0, '0, '0, 2'b00, 2'b01);
    drive(1, '0, '0, '0, '0, 2'b00, '0);

    // Reset mid-count takes effect without a clock edge.
    drive(1, '0, '0, 2'b11, {8'd100, 8'd100}, 2'b00, 2'b11);
    async_reset_pulse();
    drive(1, '0, '0, '0, '0, 2'b00, '0);

    // Unit-step sweep through the full range on ch0 in saturate mode.
    for (int i = 0; i < 256; i++) drive(1, 4'b0001, '0, '0, '0, 2'b00, '0);
    for (int i = 0; i < 256; i++) drive(1, '0, 4'b0001, '0, '0, 2'b00, '0);

    // Random traffic on both channels.
    for (int i = 0; i < 300; i++) begin
      logic [CH-1:0] ld, cl;
      for (int c = 0; c < CH; c++) begin
        ld[c] = ($urandom_range(0, 7) == 0);
        cl[c] = ($urandom_range(0, 3) == 0);
      end
      drive(1, 4'($urandom), 4'($urandom), ld, 16'($urandom), 2'($urandom), cl);
    end

    @(negedge clk);
    inc = '0; dec = '0; load = '0; clr_flags = '0;
    @(posedge clk);
    #4;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending=%0d required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
